// File: rtl/btn_event_queue_if.sv
// CPU-side bus of the button event queue: pop/clear controls plus head, flags and debounced levels.
interface btn_event_queue_if;
    logic       rd_en;
    logic       clr_ovf;
    logic [3:0] rd_data;
    logic       empty;
    logic       ovf;
    logic [7:0] state;

    modport master (output rd_en, clr_ovf, input rd_data, empty, ovf, state);
    modport slave  (input rd_en, clr_ovf, output rd_data, empty, ovf, state);
endinterface

// File: rtl/btn_event_queue.sv
// Debounces 8 buttons on a prescaled strobe and queues press (and, with BTN_RELEASE_EVT_EN,
// release) events in a show-ahead FIFO with a sticky overflow flag.
module btn_event_queue #(
    parameter int PRESCALE_W   = 10,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          btin,
    btn_event_queue_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

    logic [7:0]                 sync1, sync2, lvl;
    logic [PRESCALE_W-1:0]      pre;
    logic                       strobe;
    logic [7:0][CW-1:0]         cnt;
    logic [7:0]                 diff, qual, win;
    logic [2:0]                 idx;
    logic                       new_lvl, push, pop, wr, drop, full, empty_q;
    logic [3:0]                 code;
    logic [AW:0]                wptr, rptr;
    logic [FIFO_DEPTH-1:0][3:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            pre   <= '0;
        end else begin
            sync1 <= btin;
            sync2 <= sync1;
            pre   <= pre + PRESCALE_W'(1);
        end
    end

    assign strobe = (pre == '0);
    assign diff   = sync2 ^ lvl;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_btn
            assign qual[i] = strobe & diff[i] & (cnt[i] == CNT_MAX);

            // Qualified losers keep their saturated count and win on a later strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt[i] <= '0;
                else if (strobe) begin
                    if (!diff[i] || win[i])
                        cnt[i] <= '0;
                    else if (cnt[i] != CNT_MAX)
                        cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    endgenerate

    assign win = qual & (~qual + 8'd1);

    always_comb begin
        idx = '0;
        for (int k = 0; k < 8; k++)
            if (win[k]) idx = 3'(k);
    end

    assign new_lvl = sync2[idx];

`ifdef BTN_RELEASE_EVT_EN
    assign code = {~new_lvl, idx};
    assign push = |qual;
`else
    assign code = {1'b0, idx};
    assign push = (|qual) & new_lvl;
`endif

    assign empty_q = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = bus.rd_en & ~empty_q;
    assign wr      = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            mem     <= '0;
            bus.ovf <= 1'b0;
        end else begin
            if (|qual)
                lvl <= lvl ^ win;
            if (wr) begin
                mem[wptr[AW-1:0]] <= code;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop)
                rptr <= rptr + (AW+1)'(1);
            if (drop)
                bus.ovf <= 1'b1;
            else if (bus.clr_ovf)
                bus.ovf <= 1'b0;
        end
    end

    assign bus.rd_data = mem[rptr[AW-1:0]];
    assign bus.empty   = empty_q;
    assign bus.state   = lvl;
endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue with PRESCALE_W=2, DEBOUNCE_CNT=4, FIFO_DEPTH=8.
module tb_btn_event_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btin = 8'h00;
    int         checks = 0;
    int         errors = 0;

    btn_event_queue_if bus ();

    btn_event_queue #(.PRESCALE_W(2), .DEBOUNCE_CNT(4), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btin  (btin),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench just before the first post-reset edge (E1), where the strobe fires.
    task automatic do_reset(input logic [7:0] b);
        btin        = b;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pop1;
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset(8'h00);
        chk("rst_empty", bus.empty, 1);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_state", bus.state, 8'h00);
        chk("rst_rd_data", bus.rd_data, 4'h0);

        // Button 2 held through reset: press commits on E17
        do_reset(8'h04);
        tick(16);
        chk("b2_empty_before", bus.empty, 1);
        chk("b2_state_before", bus.state, 8'h00);
        tick(1);
        chk("b2_empty_after", bus.empty, 0);
        chk("b2_code", bus.rd_data, 4'h2);
        chk("b2_state", bus.state, 8'h04);
        tick(60);
        chk("b2_still_one", bus.empty, 0);
        pop1();
        chk("b2_single_event", bus.empty, 1);

        // Bouncing bit 0: two strobes high, two low
        do_reset(8'h00);
        for (int t = 0; t < 20; t++) begin
            tick(8);
            btin[0] = ~btin[0];
        end
        chk("bounce_empty", bus.empty, 1);
        chk("bounce_state", bus.state, 8'h00);

        // Buttons 0 and 7 together: 0 on E21, 7 on E25
        do_reset(8'h00);
        tick(3);
        btin = 8'h81;
        tick(18);
        chk("dual_first_empty", bus.empty, 0);
        chk("dual_first_code", bus.rd_data, 4'h0);
        chk("dual_first_state", bus.state, 8'h01);
        pop1();
        chk("dual_popped", bus.empty, 1);
        tick(2);
        chk("dual_gap", bus.empty, 1);
        tick(1);
        chk("dual_second_empty", bus.empty, 0);
        chk("dual_second_code", bus.rd_data, 4'h7);
        chk("dual_second_state", bus.state, 8'h81);

        // Overflow: 8 presses fill the queue, a ninth press is dropped
        do_reset(8'hFF);
        tick(45);
        chk("fill_empty", bus.empty, 0);
        chk("fill_ovf_clear", bus.ovf, 0);
        chk("fill_state", bus.state, 8'hFF);
        btin = 8'hFE;
        tick(40);
        chk("rel0_state", bus.state, 8'hFE);
        btin = 8'hFF;
        tick(40);
        chk("ovf_set", bus.ovf, 1);
        chk("ovf_state", bus.state, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_pop%0d", k), bus.rd_data, k);
            pop1();
        end
        chk("ovf_drained", bus.empty, 1);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("pop_when_empty", bus.empty, 1);
        chk("ovf_sticky", bus.ovf, 1);
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared", bus.ovf, 0);

        // Full queue, push and pop on the same edge (press of 0 commits on E77)
        do_reset(8'hFF);
        tick(46);
        btin = 8'hFE;
        tick(16);
        bus.clr_ovf = 1'b1;
        btin        = 8'hFF;
        tick(1);
        bus.clr_ovf = 1'b0;
        tick(13);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("pp_ovf", bus.ovf, 0);
        chk("pp_head", bus.rd_data, 4'h1);
        chk("pp_state", bus.state, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pp_pop%0d", k), bus.rd_data, (k + 1) % 8);
            pop1();
        end
        chk("pp_count8", bus.empty, 1);

        // Press then release of button 3
        do_reset(8'h08);
        tick(17);
        chk("b3_press_code", bus.rd_data, 4'h3);
        chk("b3_press_state", bus.state, 8'h08);
        pop1();
        btin = 8'h00;
        tick(15);
        chk("b3_release_state", bus.state, 8'h00);
`ifdef BTN_RELEASE_EVT_EN
        chk("b3_release_empty", bus.empty, 0);
        chk("b3_release_code", bus.rd_data, 4'hB);
`else
        chk("b3_release_empty", bus.empty, 1);
`endif

        // Reset asserted with an entry queued and counts pending
        do_reset(8'hFF);
        tick(20);
        chk("mid_occupied", bus.empty, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", bus.empty, 1);
        chk("mid_rst_state", bus.state, 8'h00);
        chk("mid_rst_rd_data", bus.rd_data, 4'h0);
        chk("mid_rst_ovf", bus.ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_event_queue.md
BTN_EVENT_QUEUE -- requirements
Module: btn_event_queue

Interface
REQ-001 The block SHALL have parameter PRESCALE_W, default 10: the sample strobe fires once every 2^PRESCALE_W clk cycles.
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 4: the number of consecutive strobes a mismatch must persist before it is accepted.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8: event queue entries, a power of two, minimum 2.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-006 The block SHALL have port btin, input, width 8: raw button snapshot from the serial shift-in stage, asynchronous to clk.
REQ-007 The block SHALL have port rd_en, input, width 1: pop request from the CPU bus.
REQ-008 The block SHALL have port clr_ovf, input, width 1: clears the overflow flag.
REQ-009 The block SHALL have port rd_data, output, width 4: FIFO head, where bit 3 = release(1)/press(0) and bits 2:0 = button index.
REQ-010 The block SHALL have port empty, output, width 1: the FIFO holds no entries.
REQ-011 The block SHALL have port ovf, output, width 1: sticky flag, set when an event is dropped.
REQ-012 The block SHALL have port state, output, width 8: the debounced button levels.

Function
REQ-013 Each btin bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 A free-running PRESCALE_W-bit counter SHALL assert a one-cycle strobe when it equals 0.
REQ-015 On each strobe, every button whose synchronized value differs from state SHALL increment its counter, and every button whose synchronized value equals state SHALL clear its counter.
REQ-016 A button SHALL qualify on the strobe where its counter equals DEBOUNCE_CNT-1 and the mismatch is still present; counters SHALL saturate at DEBOUNCE_CNT-1.
REQ-017 Only the lowest-index qualifying button SHALL commit per strobe: its state bit toggles, its counter clears, and the event is pushed on the same edge; other qualifying buttons SHALL hold their counters and commit on later strobes.
REQ-018 The event code SHALL be {~new_level... no: bit3 = 1 when the new level is 0 (release), 0 when the new level is 1 (press); bits 2:0 = index}.
REQ-019 The FIFO SHALL be show-ahead: rd_data SHALL present the head combinationally from storage, and empty SHALL deassert the cycle after the push edge.
REQ-020 rd_en while not empty SHALL pop the head on that edge; rd_en while empty SHALL be ignored, with no pointer change and no error.
REQ-021 A push while full without a simultaneous pop SHALL discard the event, set ovf, and still update state.
REQ-022 A push and a pop on the same edge while full SHALL both occur; ovf SHALL stay unchanged.
REQ-023 When the queue is empty, a push and a pop on the same edge SHALL leave the pop ignored and the push stored.
REQ-024 clr_ovf SHALL clear ovf on the next edge; if a set and a clear coincide, ovf SHALL be set.
REQ-025 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full SHALL be determined from the pointer MSB difference.

Reset
REQ-026 While rst_n = 0, the block SHALL hold synchronizers, state, counters, prescaler and pointers at 0, with empty = 1, ovf = 0, and rd_data = 0.
REQ-027 Reset asserted mid-debounce or with the queue occupied SHALL discard all pending counts and entries immediately.
REQ-028 After rst_n deassertion, a button already held SHALL generate a press event after normal debounce.

Configuration
REQ-029 With BTN_RELEASE_EVT_EN defined, release transitions SHALL be queued with bit 3 = 1.
REQ-030 Without BTN_RELEASE_EVT_EN, releases SHALL update state and clear counters but push nothing, and rd_data bit 3 SHALL always read 0.

Verification (PRESCALE_W=2, DEBOUNCE_CNT=4, FIFO_DEPTH=8 for the bench)
REQ-031 Holding btin=8'h04 for 20 strobes from reset -> exactly one event 4'h2; state=8'h04; empty deasserts one cycle after the 4th strobe.
REQ-032 btin bit 0 toggling every 2 strobes for 40 strobes -> no event; state bit 0 stays 0.
REQ-033 btin=8'h00 -> 8'h81 held -> events 4'h0 then 4'h7, pushed on consecutive strobes.
REQ-034 9 press events pushed with no reads -> empty=0 with 8 entries, ovf=1; popping 8 yields the first 8 in order; clr_ovf -> ovf=0.
REQ-035 Queue full, push and rd_en on the same edge -> ovf stays 0, count stays 8, head advances.
REQ-036 With BTN_RELEASE_EVT_EN defined, press then release of button 3 -> 4'h3 then 4'hB; without it -> only 4'h3, and state bit 3 returns to 0.
